prot_unpacked_pipe: RTL and testbench
=====================================

Name: prot_unpacked_pipe

Overview:
- Parametrised successor to the combinational unpacked-array pass-through used by the DPI protected-library tests.
- Carries an unpacked array of ELEMS elements, each WIDTH bits, through a DEPTH-stage elastic valid/ready pipeline.
- Applies a per-transfer element transform selected by in_mode.
- Counts completed output transfers, so unpacked ports can be exercised across a protected-library boundary with real sequential state.

Parameters:
- ELEMS, 8: number of unpacked elements; must be >= 2.
- WIDTH, 1: bits per element; must be >= 1.
- DEPTH, 2: pipeline stages; must be >= 1.
- CNT_W, 8: width of the transfer counter.

Ports:
- clk  input  1: single clock; all state updates on the rising edge.
- rst  input  1: synchronous, active-high reset.
- in_valid  input  1: upstream offers in_data/in_mode.
- in_ready  output  1: block accepts this cycle.
- in_mode  input  2: transform selector, sampled on acceptance.
- in_data  input  WIDTH x [ELEMS-1:0] unpacked: input element array.
- out_valid  output  1: out_data holds a valid item.
- out_ready  input  1: downstream accepts.
- out_data  output  WIDTH x [ELEMS-1:0] unpacked: output element array, driven from the last stage register.
- xfer_count  output  CNT_W: number of completed output transfers, modulo 2^CNT_W.

Behaviour:
- Stage storage:
  - Stages s0..s(DEPTH-1); each holds v[k] (1 bit) and d[k] (ELEMS x WIDTH).
  - out_valid = v[DEPTH-1]; out_data = d[DEPTH-1].
- Ready chain (combinational):
  - r[DEPTH-1] = !v[DEPTH-1] || out_ready.
  - r[k] = !v[k] || r[k+1].
  - in_ready = r[0] && !rst.
- Stage advance:
  - s0 loads transform(in_data, in_mode) when in_valid && in_ready.
  - Stage k+1 loads d[k] when v[k] && r[k+1].
  - A stage whose data moves on and receives nothing clears its v.
  - A stage not advancing holds d and v unchanged (stall holds data stable).
- Transform, computed combinationally at s0 input:
  - mode 0: pass, out[i] = in[i].
  - mode 1: reverse, out[i] = in[ELEMS-1-i].
  - mode 2: rotate, out[i] = in[(i+1) mod ELEMS]; element 0 moves to index ELEMS-1.
  - mode 3: invert, out[i] = ~in[i], bitwise per element.
- Latency and throughput:
  - An item accepted at edge N presents on out_valid after edge N+DEPTH-1, i.e. visible in the cycle following edge N+DEPTH-1, when there is no backpressure.
  - Sustained throughput is 1 item per cycle when out_ready is held 1.
- Ordering: strict FIFO. No item is dropped or duplicated. Capacity is DEPTH items.
- Full pipeline: all v=1 and out_ready=0 gives in_ready=0. out_ready=1 with all stages full gives in_ready=1 in the same cycle (pass-through advance, no bubble).
- Empty pipeline: out_valid=0. out_data holds the last value it held; it is not required to be zero except after reset.
- Counter:
  - xfer_count increments by 1 on each edge where out_valid && out_ready.
  - It wraps from 2^CNT_W-1 to 0.
- Reset, synchronous:
  - While rst=1 at an edge: all v=0, all d=0, xfer_count=0.
  - Outputs after that edge: out_valid=0, out_data all zero, xfer_count=0.
  - in_ready=0 whenever rst=1.
  - Reset mid-operation discards all in-flight items. No transfer is counted on a reset edge.
- Simultaneous events: an accept and an output transfer in the same cycle are both honoured. The counter and the pipeline update independently on the same edge.
- Unknown/illegal values: none; all 4 modes are defined.

Test Plan:
- Reset, then ELEMS=8, WIDTH=1, DEPTH=2; drive in_data={1,0,1,1,0,0,0,1} (index 7..0), mode 0, out_ready=1 -> identical array on out_valid 2 cycles after acceptance; xfer_count=1.
- Same data with modes 1, 2, 3 back-to-back on consecutive cycles -> outputs on consecutive cycles: reversed {1,0,0,0,1,1,0,1}; rotated {1,1,0,1,1,0,0,0}; inverted {0,1,0,0,1,1,1,0}; xfer_count=3.
- out_ready=0 and push 3 items with DEPTH=2 -> only 2 accepted, in_ready=0 on the 3rd, out_data stable. Raise out_ready -> items emerge in order, third accepted the same cycle the first leaves.
- WIDTH=8, ELEMS=4, DEPTH=4, random valid/ready toggling over 1000 items, scoreboard -> all items in order, each correctly transformed, xfer_count=1000 mod 256=232.
- CNT_W=4, 17 transfers -> xfer_count reads 15 then 0 then 1.
- Assert rst with 2 items in flight and out_ready=1 -> after the edge out_valid=0, out_data=0, xfer_count=0, in_ready=0 during rst; no stale item appears after release.

Source files
------------

// File: rtl/prot_unpacked_pipe.sv
// Elastic DEPTH-stage valid/ready pipeline carrying an unpacked element array,
// with a per-item element transform at entry and a completed-transfer counter.
module prot_unpacked_pipe #(
  parameter int ELEMS = 8,
  parameter int WIDTH = 1,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_data [ELEMS-1:0],
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data [ELEMS-1:0],
  output logic [CNT_W-1:0] xfer_count
);

  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] rdy;
  logic             chain;
  logic             accept;
  logic [WIDTH-1:0] d_q [DEPTH-1:0][ELEMS-1:0];
  logic [WIDTH-1:0] d_d [DEPTH-1:0][ELEMS-1:0];
  logic [WIDTH-1:0] xf  [ELEMS-1:0];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A stage can take new data if it is empty or its own content moves on.
  always_comb begin
    rdy = '0;
    chain = !v_q[DEPTH-1] || out_ready;
    rdy[DEPTH-1] = chain;
    for (int k = DEPTH-2; k >= 0; k--) begin
      chain = !v_q[k] || chain;
      rdy[k] = chain;
    end
  end

  assign in_ready = rdy[0] && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    for (int i = 0; i < ELEMS; i++) begin
      case (in_mode)
        2'd0:    xf[i] = in_data[i];
        2'd1:    xf[i] = in_data[ELEMS-1-i];
        2'd2:    xf[i] = in_data[(i+1) % ELEMS];
        default: xf[i] = ~in_data[i];
      endcase
    end
  end

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (accept) begin
      v_d[0] = 1'b1;
      d_d[0] = xf;
    end else if (rdy[0]) begin
      v_d[0] = 1'b0;
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (v_q[k-1] && rdy[k]) begin
        v_d[k] = 1'b1;
        d_d[k] = d_q[k-1];
      end else if (rdy[k]) begin
        v_d[k] = 1'b0;
      end
    end
    cnt_d = cnt_q;
    if (out_valid && out_ready) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        for (int i = 0; i < ELEMS; i++) d_q[k][i] <= '0;
      end
    end else begin
      v_q   <= v_d;
      d_q   <= d_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid  = v_q[DEPTH-1];
  assign xfer_count = cnt_q;

  always_comb begin
    for (int i = 0; i < ELEMS; i++) out_data[i] = d_q[DEPTH-1][i];
  end

endmodule

// File: tb/tb_prot_unpacked_pipe.sv
// Directed and scoreboarded bench for prot_unpacked_pipe in three parameter sets.
module tb_prot_unpacked_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // A: ELEMS=8 WIDTH=1 DEPTH=2 CNT_W=8
  logic       a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [1:0] a_mode;
  logic [0:0] a_in  [7:0];
  logic [0:0] a_out [7:0];
  logic [7:0] a_cnt, a_out_p;

  prot_unpacked_pipe #(.ELEMS(8), .WIDTH(1), .DEPTH(2), .CNT_W(8)) u_a (
    .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_mode(a_mode), .in_data(a_in), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out), .xfer_count(a_cnt));

  always_comb begin
    a_out_p = '0;
    for (int i = 0; i < 8; i++) a_out_p[i] = a_out[i][0];
  end

  // B: ELEMS=4 WIDTH=8 DEPTH=4 CNT_W=8
  logic        b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [1:0]  b_mode;
  logic [7:0]  b_in  [3:0];
  logic [7:0]  b_out [3:0];
  logic [7:0]  b_cnt;
  logic [31:0] b_out_p;

  prot_unpacked_pipe #(.ELEMS(4), .WIDTH(8), .DEPTH(4), .CNT_W(8)) u_b (
    .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_mode(b_mode), .in_data(b_in), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out), .xfer_count(b_cnt));

  assign b_out_p = {b_out[3], b_out[2], b_out[1], b_out[0]};

  // C: ELEMS=4 WIDTH=8 DEPTH=1 CNT_W=4
  logic       c_rst, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [1:0] c_mode;
  logic [7:0] c_in  [3:0];
  logic [7:0] c_out [3:0];
  logic [3:0] c_cnt;

  prot_unpacked_pipe #(.ELEMS(4), .WIDTH(8), .DEPTH(1), .CNT_W(4)) u_c (
    .clk(clk), .rst(c_rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_mode(c_mode), .in_data(c_in), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_data(c_out), .xfer_count(c_cnt));

  localparam logic [7:0] PAT = 8'b1011_0001;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic [7:0] v);
    for (int i = 0; i < 8; i++) a_in[i] = v[i];
  endtask

  function automatic logic [31:0] model_b(input logic [31:0] x, input logic [1:0] m);
    case (m)
      2'd0:    return x;
      2'd1:    return {x[7:0], x[15:8], x[23:16], x[31:24]};
      2'd2:    return {x[7:0], x[31:8]};
      default: return ~x;
    endcase
  endfunction

  task automatic test_reset();
    a_in_valid = 1'b1;
    a_drive(8'hFF);
    a_out_ready = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready_pre: got %b expected 0", a_in_ready); end
    tick();
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", a_out_valid); end
    checks++; if (a_out_p !== 8'h00) begin errors++; $display("FAIL rst_out_data: got %h expected 00", a_out_p); end
    checks++; if (a_cnt !== 8'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", a_cnt); end
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", a_in_ready); end
    checks++; if (c_cnt !== 4'd0) begin errors++; $display("FAIL rst_c_count: got %0d expected 0", c_cnt); end
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    a_in_valid = 1'b0;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", a_in_ready); end
  endtask

  task automatic test_pass();
    a_drive(PAT); a_mode = 2'd0; a_in_valid = 1'b1; a_out_ready = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL pass_in_ready: got %b expected 1", a_in_ready); end
    tick();
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL pass_early_valid: got %b expected 0", a_out_valid); end
    tick();
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL pass_valid: got %b expected 1", a_out_valid); end
    checks++; if (a_out_p !== PAT) begin errors++; $display("FAIL pass_data: got %b expected %b", a_out_p, PAT); end
    tick();
    checks++; if (a_cnt !== 8'd1) begin errors++; $display("FAIL pass_count: got %0d expected 1", a_cnt); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL pass_drain: got %b expected 0", a_out_valid); end
  endtask

  task automatic test_back_to_back_modes();
    logic [7:0] exp_m [1:3];
    exp_m[1] = 8'b1000_1101;
    exp_m[2] = 8'b1101_1000;
    exp_m[3] = 8'b0100_1110;
    a_rst = 1'b1; tick(); a_rst = 1'b0;
    a_drive(PAT); a_in_valid = 1'b1; a_out_ready = 1'b1;
    for (int m = 1; m <= 3; m++) begin
      a_mode = 2'(m);
      tick();
      if (m >= 2) begin
        checks++; if (a_out_valid !== 1'b1 || a_out_p !== exp_m[m-1]) begin errors++; $display("FAIL mode%0d_out: got v=%b %b expected v=1 %b", m-1, a_out_valid, a_out_p, exp_m[m-1]); end
      end
    end
    a_in_valid = 1'b0;
    tick();
    checks++; if (a_out_valid !== 1'b1 || a_out_p !== exp_m[3]) begin errors++; $display("FAIL mode3_out: got v=%b %b expected v=1 %b", a_out_valid, a_out_p, exp_m[3]); end
    tick();
    checks++; if (a_cnt !== 8'd3) begin errors++; $display("FAIL modes_count: got %0d expected 3", a_cnt); end
  endtask

  task automatic test_backpressure();
    a_out_ready = 1'b0; a_mode = 2'd0; a_in_valid = 1'b1;
    a_drive(8'h11);
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b expected 1", a_in_ready); end
    tick();
    a_drive(8'h22);
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready2: got %b expected 1", a_in_ready); end
    tick();
    a_drive(8'h33);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b expected 0", a_in_ready); end
      checks++; if (a_out_valid !== 1'b1 || a_out_p !== 8'h11) begin errors++; $display("FAIL bp_stall_data: got v=%b %h expected v=1 11", a_out_valid, a_out_p); end
      tick();
    end
    a_out_ready = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_passthru_ready: got %b expected 1", a_in_ready); end
    tick();
    a_in_valid = 1'b0;
    checks++; if (a_out_p !== 8'h22 || a_cnt !== 8'd4) begin errors++; $display("FAIL bp_second: got %h cnt %0d expected 22 cnt 4", a_out_p, a_cnt); end
    tick();
    checks++; if (a_out_valid !== 1'b1 || a_out_p !== 8'h33) begin errors++; $display("FAIL bp_third: got v=%b %h expected v=1 33", a_out_valid, a_out_p); end
    tick();
    checks++; if (a_out_valid !== 1'b0 || a_cnt !== 8'd6) begin errors++; $display("FAIL bp_drain: got v=%b cnt %0d expected v=0 cnt 6", a_out_valid, a_cnt); end
  endtask

  task automatic test_reset_midflight();
    a_out_ready = 1'b1; a_mode = 2'd0; a_in_valid = 1'b1;
    a_drive(8'hA5); tick();
    a_drive(8'h5A); tick();
    checks++; if (a_out_valid !== 1'b1 || a_out_p !== 8'hA5) begin errors++; $display("FAIL mid_pre: got v=%b %h expected v=1 a5", a_out_valid, a_out_p); end
    a_rst = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready: got %b expected 0", a_in_ready); end
    tick();
    checks++; if (a_out_valid !== 1'b0 || a_out_p !== 8'h00) begin errors++; $display("FAIL mid_flush: got v=%b %h expected v=0 00", a_out_valid, a_out_p); end
    checks++; if (a_cnt !== 8'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", a_cnt); end
    a_rst = 1'b0; a_in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (a_out_valid !== 1'b0 || a_cnt !== 8'd0) begin errors++; $display("FAIL mid_stale: got v=%b cnt %0d expected v=0 cnt 0", a_out_valid, a_cnt); end
    end
  endtask

  task automatic test_random_stream();
    logic [31:0] q [$];
    logic [31:0] cur, expv;
    int sent, got, cyc;
    bit acc;
    sent = 0; got = 0; cyc = 0;
    cur = $urandom; b_mode = 2'($urandom_range(0, 3));
    for (int i = 0; i < 4; i++) b_in[i] = cur[8*i +: 8];
    while (got < 1000 && cyc < 20000) begin
      b_in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = b_in_valid && b_in_ready;
      if (acc) begin
        q.push_back(model_b(cur, b_mode));
        sent++;
      end
      if (b_out_valid && b_out_ready) begin
        expv = (q.size() > 0) ? q.pop_front() : ~b_out_p;
        checks++; if (b_out_p !== expv) begin errors++; $display("FAIL rand_item%0d: got %h expected %h", got, b_out_p, expv); end
        got++;
      end
      tick();
      if (acc) begin
        cur = $urandom; b_mode = 2'($urandom_range(0, 3));
        for (int i = 0; i < 4; i++) b_in[i] = cur[8*i +: 8];
      end
      cyc++;
    end
    b_in_valid = 1'b0;
    checks++; if (got != 1000) begin errors++; $display("FAIL rand_timeout: got %0d items expected 1000", got); end
    checks++; if (b_cnt !== 8'd232) begin errors++; $display("FAIL rand_count: got %0d expected 232", b_cnt); end
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL rand_empty: got %b expected 0", b_out_valid); end
  endtask

  task automatic test_counter_wrap();
    c_mode = 2'd0; c_out_ready = 1'b1; c_in_valid = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      for (int i = 0; i < 4; i++) c_in[i] = 8'(k * 4 + i);
      #1;
      checks++; if (c_in_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready%0d: got %b expected 1", k, c_in_ready); end
      tick();
      checks++; if (c_cnt !== 4'((k - 1) % 16)) begin errors++; $display("FAIL wrap_count%0d: got %0d expected %0d", k, c_cnt, (k - 1) % 16); end
      checks++; if (c_out_valid !== 1'b1 || c_out[0] !== 8'(k * 4) || c_out[3] !== 8'(k * 4 + 3)) begin errors++; $display("FAIL wrap_data%0d: got v=%b %h %h expected v=1 %h %h", k, c_out_valid, c_out[0], c_out[3], 8'(k * 4), 8'(k * 4 + 3)); end
    end
    c_in_valid = 1'b0;
  endtask

  initial begin
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
    a_out_ready = 1'b0; b_out_ready = 1'b0; c_out_ready = 1'b0;
    a_mode = 2'd0; b_mode = 2'd0; c_mode = 2'd0;
    a_drive(8'h00);
    for (int i = 0; i < 4; i++) begin b_in[i] = 8'h00; c_in[i] = 8'h00; end
    test_reset();
    test_pass();
    test_back_to_back_modes();
    test_backpressure();
    test_reset_midflight();
    test_random_stream();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
